// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_unit
// Description : Multicycle-CPU memory access sequencer. It issues one fetch,
//               load or store at a time, with an error path and a timeout,
//               and holds the IR/MDR registers.
// Revision    : 1.0
// ============================================================================
module mem_access_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        acc_req,
    input  logic        IorD,
    input  logic        MemWrite,
    input  logic [31:0] pc,
    input  logic [31:0] alu_out,
    input  logic [31:0] wdata,
    output logic        m_valid,
    output logic [31:0] m_addr,
    output logic        m_we,
    output logic [31:0] m_wdata,
    input  logic        m_ready,
    input  logic [31:0] m_rdata,
    output logic        acc_done,
    output logic        acc_err,
    output logic        busy,
    output logic [31:0] ir,
    output logic [31:0] mdr,
    output logic [5:0]  opcode,
    output logic [5:0]  funct,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [4:0]  shamt,
    output logic [15:0] imm16,
    output logic [25:0] jtarget
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Counter value on the 255th WAIT cycle; a miss here is the timeout.
    localparam logic [7:0] C_CNT_LAST = 8'd254;

    state_t      r_state_q, w_state_d;
    logic [31:0] r_addr_q,  w_addr_d;
    logic        r_we_q,    w_we_d;
    logic [31:0] r_wdata_q, w_wdata_d;
    logic        r_iord_q,  w_iord_d;
    logic        r_err_q,   w_err_d;
    logic [7:0]  r_cnt_q,   w_cnt_d;
    logic [31:0] r_ir_q,    w_ir_d;
    logic [31:0] r_mdr_q,   w_mdr_d;

    logic [31:0] w_sel_addr;
    logic        w_illegal;

    assign w_sel_addr = IorD ? alu_out : pc;
    assign w_illegal  = (w_sel_addr[1:0] != 2'b00) || (!IorD && MemWrite);

    always_comb begin
        w_state_d = r_state_q;
        w_addr_d  = r_addr_q;
        w_we_d    = r_we_q;
        w_wdata_d = r_wdata_q;
        w_iord_d  = r_iord_q;
        w_err_d   = r_err_q;
        w_cnt_d   = r_cnt_q;
        w_ir_d    = r_ir_q;
        w_mdr_d   = r_mdr_q;

        case (r_state_q)
            ST_IDLE: begin
                if (acc_req) begin
                    w_addr_d  = w_sel_addr;
                    w_we_d    = MemWrite;
                    w_wdata_d = wdata;
                    w_iord_d  = IorD;
                    w_cnt_d   = 8'd0;
                    w_err_d   = w_illegal;
                    w_state_d = w_illegal ? ST_DONE : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (m_ready) begin
                    w_err_d   = 1'b0;
                    w_state_d = ST_DONE;
                    if (!r_we_q) begin
                        if (r_iord_q) w_mdr_d = m_rdata;
                        else          w_ir_d  = m_rdata;
                    end
                end else begin
                    w_cnt_d = r_cnt_q + 8'd1;
                    if (r_cnt_q == C_CNT_LAST) begin
                        w_err_d   = 1'b1;
                        w_state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                w_state_d = ST_IDLE;
            end
            default: begin
                w_state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q <= ST_IDLE;
            r_addr_q  <= 32'd0;
            r_we_q    <= 1'b0;
            r_wdata_q <= 32'd0;
            r_iord_q  <= 1'b0;
            r_err_q   <= 1'b0;
            r_cnt_q   <= 8'd0;
            r_ir_q    <= 32'd0;
            r_mdr_q   <= 32'd0;
        end else begin
            r_state_q <= w_state_d;
            r_addr_q  <= w_addr_d;
            r_we_q    <= w_we_d;
            r_wdata_q <= w_wdata_d;
            r_iord_q  <= w_iord_d;
            r_err_q   <= w_err_d;
            r_cnt_q   <= w_cnt_d;
            r_ir_q    <= w_ir_d;
            r_mdr_q   <= w_mdr_d;
        end
    end

    assign m_valid  = (r_state_q == ST_WAIT);
    assign m_addr   = r_addr_q;
    assign m_we     = r_we_q & m_valid;
    assign m_wdata  = r_wdata_q;
    assign acc_done = (r_state_q == ST_DONE);
    assign acc_err  = r_err_q & acc_done;
    assign busy     = (r_state_q != ST_IDLE);

    assign ir      = r_ir_q;
    assign mdr     = r_mdr_q;
    assign opcode  = r_ir_q[31:26];
    assign rs      = r_ir_q[25:21];
    assign rt      = r_ir_q[20:16];
    assign rd      = r_ir_q[15:11];
    assign shamt   = r_ir_q[10:6];
    assign funct   = r_ir_q[5:0];
    assign imm16   = r_ir_q[15:0];
    assign jtarget = r_ir_q[25:0];

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_access_unit
// Description : Self-checking bench for mem_access_unit: directed vector table,
//               reset-mid-access sequence and randomized transactions.
// Revision    : 1.0
// ============================================================================
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        acc_req;
    logic        IorD;
    logic        MemWrite;
    logic [31:0] pc;
    logic [31:0] alu_out;
    logic [31:0] wdata;
    logic        m_valid;
    logic [31:0] m_addr;
    logic        m_we;
    logic [31:0] m_wdata;
    logic        m_ready;
    logic [31:0] m_rdata;
    logic        acc_done;
    logic        acc_err;
    logic        busy;
    logic [31:0] ir;
    logic [31:0] mdr;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [15:0] imm16;
    logic [25:0] jtarget;

    mem_access_unit dut (
        .clk(clk), .rst(rst), .acc_req(acc_req), .IorD(IorD), .MemWrite(MemWrite),
        .pc(pc), .alu_out(alu_out), .wdata(wdata),
        .m_valid(m_valid), .m_addr(m_addr), .m_we(m_we), .m_wdata(m_wdata),
        .m_ready(m_ready), .m_rdata(m_rdata),
        .acc_done(acc_done), .acc_err(acc_err), .busy(busy),
        .ir(ir), .mdr(mdr), .opcode(opcode), .funct(funct),
        .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .imm16(imm16), .jtarget(jtarget)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Transaction-level reference state
    logic [31:0] model_ir;
    logic [31:0] model_mdr;

    typedef struct {
        logic        iord;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wd;
        int          ready_at;   // WAIT cycle carrying m_ready; 0 = never
        logic [31:0] rdat;
        logic        exp_err;
        logic [31:0] exp_ir;
        logic [31:0] exp_mdr;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_fields(input logic [31:0] e);
        chk("opcode",  {26'd0, opcode},  {26'd0, e[31:26]});
        chk("rs",      {27'd0, rs},      {27'd0, e[25:21]});
        chk("rt",      {27'd0, rt},      {27'd0, e[20:16]});
        chk("rd",      {27'd0, rd},      {27'd0, e[15:11]});
        chk("shamt",   {27'd0, shamt},   {27'd0, e[10:6]});
        chk("funct",   {26'd0, funct},   {26'd0, e[5:0]});
        chk("imm16",   {16'd0, imm16},   {16'd0, e[15:0]});
        chk("jtarget", {6'd0, jtarget},  {6'd0, e[25:0]});
    endtask

    // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
    task automatic run_access(input logic iord, input logic we, input logic [31:0] addr,
                              input logic [31:0] wd, input int ready_at,
                              input logic [31:0] rdat, input logic noise,
                              output logic got_err);
        logic illegal;
        logic exp_err;
        int   k;
        logic fin;
        illegal = (addr[1:0] != 2'b00) || (!iord && we);
        exp_err = illegal || (ready_at < 1) || (ready_at > 255);

        acc_req  = 1'b1;
        IorD     = iord;
        MemWrite = we;
        pc       = iord ? $urandom : addr;
        alu_out  = iord ? addr : $urandom;
        wdata    = wd;
        m_ready  = noise ? 1'($urandom) : 1'b0;
        m_rdata  = $urandom;
        @(negedge clk);
        acc_req = 1'b0;

        if (!illegal) begin
            k   = 1;
            fin = 1'b0;
            while (!fin) begin
                chk("m_valid_wait", {31'd0, m_valid}, 32'd1);
                chk("m_addr",       m_addr, addr);
                chk("m_we",         {31'd0, m_we}, {31'd0, we});
                chk("m_wdata",      m_wdata, wd);
                chk("done_in_wait", {31'd0, acc_done}, 32'd0);
                m_ready = (k == ready_at);
                m_rdata = (k == ready_at) ? rdat : $urandom;
                if (noise) begin
                    acc_req = 1'($urandom);
                    pc      = $urandom;
                    alu_out = $urandom;
                    wdata   = $urandom;
                end
                @(negedge clk);
                acc_req = 1'b0;
                if (k == ready_at || k == 255) fin = 1'b1;
                k++;
            end
        end

        chk("acc_done", {31'd0, acc_done}, 32'd1);
        chk("acc_err",  {31'd0, acc_err},  {31'd0, exp_err});
        chk("m_valid_done", {31'd0, m_valid}, 32'd0);
        chk("busy_done", {31'd0, busy}, 32'd1);
        got_err = acc_err;
        if (!exp_err && !we) begin
            if (iord) model_mdr = rdat;
            else      model_ir  = rdat;
        end
        chk("ir",  ir,  model_ir);
        chk("mdr", mdr, model_mdr);
        m_ready = noise ? 1'($urandom) : 1'b0;
        m_rdata = $urandom;
        @(negedge clk);
        chk("done_pulse", {31'd0, acc_done}, 32'd0);
        chk("err_idle",   {31'd0, acc_err},  32'd0);
        chk("busy_idle",  {31'd0, busy},     32'd0);
        chk("m_we_idle",  {31'd0, m_we},     32'd0);
        m_ready = 1'b0;
    endtask

    initial begin
        logic        e;
        logic        r_iord;
        logic        r_we;
        logic [31:0] r_addr;
        int          r_rdy;

        vecs[0] = '{1'b0, 1'b0, 32'h00400000, 32'h0,        3,   32'h8C080004, 1'b0, 32'h8C080004, 32'h0};
        vecs[1] = '{1'b1, 1'b0, 32'h10010008, 32'h0,        1,   32'hDEADBEEF, 1'b0, 32'h8C080004, 32'hDEADBEEF};
        vecs[2] = '{1'b1, 1'b1, 32'h10010010, 32'h12345678, 4,   32'hFFFFFFFF, 1'b0, 32'h8C080004, 32'hDEADBEEF};
        vecs[3] = '{1'b1, 1'b0, 32'h10010002, 32'h0,        1,   32'h11111111, 1'b1, 32'h8C080004, 32'hDEADBEEF};
        vecs[4] = '{1'b0, 1'b1, 32'h00400004, 32'hAAAA5555, 1,   32'h22222222, 1'b1, 32'h8C080004, 32'hDEADBEEF};
        vecs[5] = '{1'b1, 1'b0, 32'h10010020, 32'h0,        0,   32'h33333333, 1'b1, 32'h8C080004, 32'hDEADBEEF};
        vecs[6] = '{1'b1, 1'b0, 32'h10010024, 32'h0,        255, 32'hCAFEF00D, 1'b0, 32'h8C080004, 32'hCAFEF00D};
        vecs[7] = '{1'b0, 1'b0, 32'h00400002, 32'h0,        1,   32'h44444444, 1'b1, 32'h8C080004, 32'hCAFEF00D};

        rst = 1'b1; acc_req = 1'b0; IorD = 1'b0; MemWrite = 1'b0;
        pc = 32'd0; alu_out = 32'd0; wdata = 32'd0; m_ready = 1'b0; m_rdata = 32'd0;
        model_ir = 32'd0; model_mdr = 32'd0;
        repeat (3) @(negedge clk);
        chk("rst_m_valid",  {31'd0, m_valid},  32'd0);
        chk("rst_m_we",     {31'd0, m_we},     32'd0);
        chk("rst_acc_done", {31'd0, acc_done}, 32'd0);
        chk("rst_acc_err",  {31'd0, acc_err},  32'd0);
        chk("rst_busy",     {31'd0, busy},     32'd0);
        chk("rst_ir",       ir,  32'd0);
        chk("rst_mdr",      mdr, 32'd0);
        chk("rst_m_addr",   m_addr, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            run_access(vecs[i].iord, vecs[i].we, vecs[i].addr, vecs[i].wd,
                       vecs[i].ready_at, vecs[i].rdat, 1'b0, e);
            chk("vec_err", {31'd0, e}, {31'd0, vecs[i].exp_err});
            chk("vec_ir",  ir,  vecs[i].exp_ir);
            chk("vec_mdr", mdr, vecs[i].exp_mdr);
            chk_fields(vecs[i].exp_ir);
        end

        // Reset while the second WAIT cycle is in progress
        acc_req = 1'b1; IorD = 1'b0; MemWrite = 1'b0; pc = 32'h00400100;
        @(negedge clk);
        acc_req = 1'b0;
        chk("rw_wait1", {31'd0, m_valid}, 32'd1);
        @(negedge clk);
        chk("rw_wait2", {31'd0, m_valid}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m_ready = 1'b1;
        m_rdata = 32'hFFFFFFFF;
        model_ir = 32'd0;
        model_mdr = 32'd0;
        for (int j = 0; j < 3; j++) begin
            chk("rw_m_valid",  {31'd0, m_valid},  32'd0);
            chk("rw_acc_done", {31'd0, acc_done}, 32'd0);
            chk("rw_busy",     {31'd0, busy},     32'd0);
            chk("rw_ir",       ir,  32'd0);
            chk("rw_mdr",      mdr, 32'd0);
            @(negedge clk);
        end
        m_ready = 1'b0;

        for (int t = 0; t < 150; t++) begin
            r_iord = 1'($urandom);
            r_we   = ($urandom_range(0, 3) == 0);
            r_addr = $urandom;
            if ($urandom_range(0, 4) != 0) r_addr[1:0] = 2'b00;
            r_rdy  = $urandom_range(1, 6);
            if ($urandom_range(0, 29) == 0) r_rdy = 0;
            if ($urandom_range(0, 29) == 0) r_rdy = $urandom_range(250, 255);
            run_access(r_iord, r_we, r_addr, $urandom, r_rdy, $urandom, 1'b1, e);
            chk_fields(model_ir);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
